// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive stream: FSM states, data width and
// the bit-period helper used to size the receiver timers.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte stream handshake carrying received UART bytes to the terminal consumer.
// The receiver drives the master side, the consumer the slave side.
interface uart_rx_stream_if;
  import uart_pkg::*;

  logic              term_tvalid;
  logic [DATA_W-1:0] term_tdata;
  logic              term_tready;

  modport master (output term_tvalid, output term_tdata, input term_tready);
  modport slave  (input term_tvalid, input term_tdata, output term_tready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer: a single holding register when DEPTH == 1, otherwise a
// power-of-two ring FIFO. Pushes into a full buffer are dropped and flagged.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overrun
);

  logic w_pop;
  logic w_full;
  logic r_overrun;

  assign w_pop = o_valid && i_ready;

  generate
    if (DEPTH == 1) begin : g_hold
      logic             r_valid;
      logic [WIDTH-1:0] r_data;

      assign w_full  = r_valid;
      assign o_valid = r_valid;
      assign o_data  = r_data;

      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (i_push && (!r_valid || w_pop)) begin
          r_valid <= 1'b1;
          r_data  <= i_data;
        end else if (w_pop) begin
          r_valid <= 1'b0;
        end
      end
    end else begin : g_ring
      localparam int PTR_W = $clog2(DEPTH);
      localparam int CNT_W = PTR_W + 1;

      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;
      logic [CNT_W-1:0] r_count;
      logic             w_push_ok;

      assign w_full    = (r_count == CNT_W'(DEPTH));
      assign w_push_ok = i_push && (!w_full || w_pop);
      assign o_valid   = (r_count != '0);
      // Empty buffer presents zero so the bus is clean after reset.
      assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

      // NOTE: storage array is deliberately not reset; the count alone
      // decides which entries are meaningful.
      always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
          case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // A same-cycle pop frees the slot, so that push is not an overrun.
  always_ff @(posedge clk) begin
    if (reset) r_overrun <= 1'b0;
    else       r_overrun <= i_push && w_full && !w_pop;
  end

  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a valid/ready byte stream. Defining
// UART_RX_FIFO_EN selects a FIFO_DEPTH-entry buffer; otherwise depth 1.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25200000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_rx,
  uart_rx_stream_if.master  term,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT + 1);
  localparam int BITCNT_W     = $clog2(DATA_W);

`ifdef UART_RX_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [1:0]          r_sync;
  logic                w_rx;
  rx_state_e           r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [BITCNT_W-1:0] r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_frame_err;
  logic                w_timer_done;
  logic                w_stop_hit;
  logic                w_push;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], ser_rx};
  end

  assign w_rx         = r_sync[1];
  assign w_timer_done = (r_timer == '0);
  assign w_stop_hit   = (r_state == ST_STOP) && w_timer_done;
  assign w_push       = w_stop_hit && w_rx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            r_state   <= ST_START;
            r_timer   <= TIMER_W'(HALF - 1);
            r_bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_timer_done) begin
            // A line that is high again at mid start bit was only a glitch.
            if (!w_rx) begin
              r_state <= ST_DATA;
              r_timer <= TIMER_W'(CLKS_PER_BIT - 1);
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_timer_done) begin
            r_shift   <= {w_rx, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_timer   <= TIMER_W'(CLKS_PER_BIT - 1);
            if (r_bit_cnt == BITCNT_W'(DATA_W - 1)) r_state <= ST_STOP;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_STOP: begin
          // Sampled mid stop bit; returning to IDLE here re-arms early.
          if (w_timer_done) begin
            r_frame_err <= !w_rx;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign frame_err = r_frame_err;

  uart_rx_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_data    (r_shift),
    .i_ready   (term.term_tready),
    .o_valid   (term.term_tvalid),
    .o_data    (term.term_tdata),
    .o_overrun (overrun)
  );

endmodule

// File: doc/uart_rx_stream.md
UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25200000, meaning the clk frequency in Hz (pixel clock domain).
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the receive FIFO entries (power of 2, >=2); used only with UART_RX_FIFO_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ser_rx, input, 1 bit: asynchronous UART line, idle high, 8N1 framing.
REQ-007 SHALL have port term_tvalid, output, 1 bit: a received byte is available.
REQ-008 SHALL have port term_tdata, output, 8 bits: the received byte, LSB = first data bit.
REQ-009 SHALL have port term_tready, input, 1 bit: the consumer (terminal input) accepts the byte.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-012 SHALL pass ser_rx through a 2-flop synchronizer whose flops reset to 1; all decisions use the synchronized value.
REQ-013 SHALL use CLKS_PER_BIT = CLK_HZ/BAUD (integer division; 218 at defaults) and HALF = CLKS_PER_BIT/2.
REQ-014 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-015 In IDLE, a synchronized low SHALL move the FSM to START and clear the bit counter.
REQ-016 In START, after HALF cycles: if the line is low, go to DATA with the bit timer reloaded; if high (glitch), return to IDLE with no output.
REQ-017 In DATA, SHALL sample every CLKS_PER_BIT cycles, shifting LSB-first; after the 8th sample, go to STOP.
REQ-018 In STOP, after CLKS_PER_BIT cycles, SHALL sample once and return to IDLE on the following cycle, re-arming start detection mid-stop-bit.
REQ-019 A stop sample of 1 SHALL push the byte into the buffer; a stop sample of 0 SHALL discard the byte and pulse frame_err for exactly 1 cycle.
REQ-020 A pushed byte SHALL appear on term_tvalid/term_tdata on the cycle after the stop sample when the buffer was empty.
REQ-021 A transfer occurs on any cycle with term_tvalid and term_tready both high; term_tdata SHALL be stable while term_tvalid is high and term_tready is low.
REQ-022 A push into a full buffer SHALL drop the new byte, keep the buffered data intact, and pulse overrun.
REQ-023 A simultaneous push and pop on a full buffer SHALL succeed with no overrun.
REQ-024 Pointer and count arithmetic SHALL wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-025 When reset is high, the FSM SHALL go to IDLE and the buffer SHALL empty, with term_tvalid=0, term_tdata=0, frame_err=0, overrun=0 and synchronizer=1 on the next cycle.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no push and no error pulse; reception restarts at the next falling edge after reset deasserts.

Configuration
REQ-027 With `UART_RX_FIFO_EN` defined, the buffer SHALL be a FIFO_DEPTH-entry FIFO.
REQ-028 Without `UART_RX_FIFO_EN`, the buffer SHALL be a single holding register (depth 1), and REQ-022 and REQ-023 apply at depth 1.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state enum, the data width constant (8) and the function computing CLKS_PER_BIT.
REQ-030 The buffer SHALL be one sub-module, uart_rx_fifo, that provides both the FIFO and the depth-1 variant.

Verification (defaults; bit = 218 clks)
REQ-031 Byte 0x55 on ser_rx with term_tready=1: term_tvalid pulses 1 cycle, term_tdata=0x55, and frame_err and overrun stay 0.
REQ-032 Back-to-back 0xA5, 0x3C with no idle gap and term_tready=1: both bytes are delivered in order.
REQ-033 A low glitch of 50 clks on an idle line: no term_tvalid and FSM back in IDLE within HALF+3 cycles.
REQ-034 Frame 0x7E with stop bit driven low: frame_err pulses 1 cycle and term_tvalid stays 0.
REQ-035 With term_tready=0, send 17 bytes 0x00..0x10 (FIFO_EN, depth 16): 1 overrun pulse, then drain gives 0x00..0x0F.
REQ-036 Assert reset during data bit 4 of 0xFF, then send 0x12: only 0x12 is delivered.
